// File: rtl/fifo_dc_prog_if.sv
// rtl/fifo_dc_prog_if.sv - producer/consumer bus of the programmable data-controller FIFO
interface fifo_dc_prog_if #(
  parameter int C_WIDTH          = 8,
  parameter int C_LOG_FIFO_DEPTH = 3
);
  logic [C_WIDTH-1:0]        buf_in;
  logic                      wr_en;
  logic                      rd_en;
  logic                      err_clr;
  logic [C_WIDTH-1:0]        buf_out;
  logic                      rd_valid;
  logic                      buf_empty;
  logic                      buf_full;
  logic                      almost_full;
  logic                      almost_empty;
  logic                      overflow;
  logic                      underflow;
  logic [C_LOG_FIFO_DEPTH:0] fifo_counter;

  modport master (
    output buf_in, wr_en, rd_en, err_clr,
    input  buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           overflow, underflow, fifo_counter
  );

  modport slave (
    input  buf_in, wr_en, rd_en, err_clr,
    output buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           overflow, underflow, fifo_counter
  );
endinterface

// File: rtl/fifo_dc_prog.sv
// rtl/fifo_dc_prog.sv - single-clock FIFO with idle-output mode, programmable flags and sticky errors
module fifo_dc_prog #(
  parameter int C_WIDTH          = 8,
  parameter int C_LOG_FIFO_DEPTH = 3,
  parameter int C_ZERO_ON_IDLE   = 1,
  parameter int C_AFULL_THRESH   = 6,
  parameter int C_AEMPTY_THRESH  = 1
) (
  input logic           clk,
  input logic           rst,
  fifo_dc_prog_if.slave bus
);
  localparam int C_DEPTH = 1 << C_LOG_FIFO_DEPTH;
  localparam int CW      = C_LOG_FIFO_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(C_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(C_AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(C_AEMPTY_THRESH);

  logic [C_WIDTH-1:0]          mem [C_DEPTH];
  logic [C_LOG_FIFO_DEPTH-1:0] rd_ptr;
  logic [C_LOG_FIFO_DEPTH-1:0] wr_ptr;
  logic [CW-1:0]               count;
  logic [C_WIDTH-1:0]          buf_out_r;
  logic                        rd_valid_r;
  logic                        overflow_r;
  logic                        underflow_r;
  logic                        empty;
  logic                        full;
  logic                        wr_acc;
  logic                        rd_acc;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  // Accepts look only at the registered count: a write while full is dropped even alongside a read.
  assign wr_acc = bus.wr_en & ~full & ~rst;
  assign rd_acc = bus.rd_en & ~empty & ~rst;

  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_full  = (count >= AFULL_C);
  assign bus.almost_empty = (count <= AEMPTY_C);
  assign bus.fifo_counter = count;
  assign bus.buf_out      = buf_out_r;
  assign bus.rd_valid     = rd_valid_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.buf_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      buf_out_r   <= '0;
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        buf_out_r  <= mem[rd_ptr];
        rd_valid_r <= 1'b1;
      end else begin
        rd_valid_r <= 1'b0;
        if (C_ZERO_ON_IDLE != 0) buf_out_r <= '0;
      end
      // A new error event outranks a simultaneous clear.
      if (bus.wr_en & full)       overflow_r <= 1'b1;
      else if (bus.err_clr)       overflow_r <= 1'b0;
      if (bus.rd_en & empty)      underflow_r <= 1'b1;
      else if (bus.err_clr)       underflow_r <= 1'b0;
    end
  end
endmodule
